// File: rtl/instr_fetch.sv
// Multicycle fetch: four byte reads assembled little-endian into a 32-bit instruction register.
// Optional FETCH_FLUSH_EN adds a flush input that abandons an in-progress fetch.
module instr_fetch #(
  parameter int WIDTH  = 8,
  parameter int INSTRW = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
`ifdef FETCH_FLUSH_EN
  input  logic              flush,
`endif
  input  logic [WIDTH-1:0]  pc,
  input  logic [WIDTH-1:0]  memdata,
  output logic              memread,
  output logic [WIDTH-1:0]  adr,
  output logic [INSTRW-1:0] instr,
  output logic              instr_valid,
  output logic              busy,
  output logic [3:0]        irwrite
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t               state_q, state_d;
  logic [WIDTH-1:0]     base_q, base_d;
  logic [1:0]           cnt_q, cnt_d;
  logic [3*WIDTH-1:0]   shadow_q, shadow_d;
  logic [INSTRW-1:0]    instr_q, instr_d;
  logic                 flush_w;

`ifdef FETCH_FLUSH_EN
  assign flush_w = flush;
`else
  assign flush_w = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= IDLE;
      base_q   <= '0;
      cnt_q    <= '0;
      shadow_q <= '0;
      instr_q  <= '0;
    end else begin
      state_q  <= state_d;
      base_q   <= base_d;
      cnt_q    <= cnt_d;
      shadow_q <= shadow_d;
      instr_q  <= instr_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    base_d   = base_q;
    cnt_d    = cnt_q;
    shadow_d = shadow_q;
    instr_d  = instr_q;
    memread  = 1'b0;
    adr      = base_q;
    irwrite  = 4'b0000;
    unique case (state_q)
      IDLE, DONE: begin
        if (start) begin
          base_d  = pc;
          cnt_d   = '0;
          state_d = FETCH;
        end else begin
          state_d = IDLE;
        end
      end
      FETCH: begin
        memread = 1'b1;
        adr     = base_q + WIDTH'(cnt_q);
        // The byte requested last cycle arrives now; lane cnt-1 takes it.
        for (int i = 0; i < 3; i++) begin
          if (cnt_q == 2'(i + 1)) begin
            shadow_d[i*WIDTH +: WIDTH] = memdata;
            irwrite[i]                 = 1'b1;
          end
        end
        cnt_d = cnt_q + 2'd1;
        if (cnt_q == 2'd3) state_d = DRAIN;
        if (flush_w) begin
          shadow_d = shadow_q;
          cnt_d    = '0;
          state_d  = IDLE;
        end
      end
      DRAIN: begin
        irwrite = 4'b1000;
        if (flush_w) begin
          cnt_d   = '0;
          state_d = IDLE;
        end else begin
          instr_d = {memdata, shadow_q};
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign instr       = instr_q;
  assign instr_valid = (state_q == DONE);
  assign busy        = (state_q == FETCH) || (state_q == DRAIN);

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: reset, basic, wrap, back-to-back, mid-fetch reset, flush.
module tb_instr_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        flush;
  logic [7:0]  pc;
  logic [7:0]  memdata;
  logic        memread;
  logic [7:0]  adr;
  logic [31:0] instr;
  logic        instr_valid;
  logic        busy;
  logic [3:0]  irwrite;

  logic [7:0]  mem [256];
  int          total = 0;
  int          bad   = 0;

  always #5 clk = ~clk;

  // Byte-wide synchronous memory: data valid one cycle after the address.
  always @(posedge clk) memdata <= mem[adr];

  instr_fetch #(.WIDTH(8), .INSTRW(32)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
`ifdef FETCH_FLUSH_EN
    .flush       (flush),
`endif
    .pc          (pc),
    .memdata     (memdata),
    .memread     (memread),
    .adr         (adr),
    .instr       (instr),
    .instr_valid (instr_valid),
    .busy        (busy),
    .irwrite     (irwrite)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Called at a negedge with the DUT idle; returns at the negedge after DONE.
  task automatic run_fetch(input logic [7:0] p, input logic [31:0] exp);
    logic [7:0] a;
    pc    = p;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    pc    = ~p;
    for (int k = 0; k < 4; k++) begin
      a = p + 8'(k);
      check("fetch_adr", 32'(adr), 32'(a));
      check("fetch_memread", 32'(memread), 32'd1);
      check("fetch_irwrite", 32'(irwrite), (k == 0) ? 32'd0 : (32'd1 << (k - 1)));
      check("fetch_busy", 32'(busy), 32'd1);
      @(negedge clk);
    end
    check("drain_memread", 32'(memread), 32'd0);
    check("drain_irwrite", 32'(irwrite), 32'h8);
    check("drain_valid", 32'(instr_valid), 32'd0);
    @(negedge clk);
    check("done_instr", instr, exp);
    check("done_valid", 32'(instr_valid), 32'd1);
    check("done_busy", 32'(busy), 32'd0);
    @(negedge clk);
    check("after_valid", 32'(instr_valid), 32'd0);
    check("after_instr", instr, exp);
    $display("fetch pc=%h instr=%h expected=%h", p, instr, exp);
  endtask

  initial begin
    logic [31:0] exp_b2b [3];
    int          n;
    for (int i = 0; i < 256; i++) mem[i] = 8'(i ^ 8'h5A);
    mem[8'h10] = 8'h20; mem[8'h11] = 8'h08; mem[8'h12] = 8'h05; mem[8'h13] = 8'h00;
    mem[8'hFE] = 8'h11; mem[8'hFF] = 8'h22; mem[8'h00] = 8'h33; mem[8'h01] = 8'h44;
    mem[8'h02] = 8'h55; mem[8'h03] = 8'h66;
    mem[8'h04] = 8'h01; mem[8'h05] = 8'h02; mem[8'h06] = 8'h03; mem[8'h07] = 8'h04;
    mem[8'h20] = 8'hDD; mem[8'h21] = 8'hCC; mem[8'h22] = 8'hBB; mem[8'h23] = 8'hAA;

    // Reset held two cycles with start asserted.
    rst = 1'b0; start = 1'b1; flush = 1'b0; pc = 8'h40;
    repeat (2) @(negedge clk);
    check("rst_memread", 32'(memread), 32'd0);
    check("rst_adr", 32'(adr), 32'd0);
    check("rst_instr", instr, 32'd0);
    check("rst_valid", 32'(instr_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_irwrite", 32'(irwrite), 32'd0);
    start = 1'b0;
    rst   = 1'b1;
    @(negedge clk);

    run_fetch(8'h10, 32'h00050820);
    run_fetch(8'hFE, 32'h44332211);

    // Back-to-back with start held; pc alternates so acceptance edges pick 00,04,00.
    exp_b2b[0] = 32'h66554433;
    exp_b2b[1] = 32'h04030201;
    exp_b2b[2] = 32'h66554433;
    start = 1'b1;
    for (int c = 0; c < 18; c++) begin
      pc = ((c % 4) < 2) ? 8'h00 : 8'h04;
      @(negedge clk);
      n = c + 1;
      if (n % 6 == 0) begin
        check("b2b_valid", 32'(instr_valid), 32'd1);
        check("b2b_instr", instr, exp_b2b[n/6 - 1]);
        $display("b2b fetch %0d instr=%h expected=%h", n/6 - 1, instr, exp_b2b[n/6 - 1]);
      end else begin
        check("b2b_novalid", 32'(instr_valid), 32'd0);
        check("b2b_busy", 32'(busy), 32'd1);
        if (n % 6 == 1)
          check("b2b_base", 32'(adr), (n == 7) ? 32'h04 : 32'h00);
      end
    end
    start = 1'b0;
    @(negedge clk);
    check("b2b_idle_busy", 32'(busy), 32'd0);

    // Reset during the third FETCH cycle discards the partial fetch.
    pc = 8'h10; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("midrst_pre_busy", 32'(busy), 32'd1);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    check("midrst_memread", 32'(memread), 32'd0);
    check("midrst_instr", instr, 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_adr", 32'(adr), 32'd0);
    $display("reset mid-fetch instr=%h", instr);
    run_fetch(8'h10, 32'h00050820);

`ifdef FETCH_FLUSH_EN
    run_fetch(8'h20, 32'hAABBCCDD);
    pc = 8'h10; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    check("flush_in_drain", 32'(irwrite), 32'h8);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("flush_instr", instr, 32'hAABBCCDD);
    check("flush_valid", 32'(instr_valid), 32'd0);
    check("flush_memread", 32'(memread), 32'd0);
    check("flush_busy", 32'(busy), 32'd0);
    @(negedge clk);
    check("flush_still_idle", 32'(busy), 32'd0);
    check("flush_instr_held", instr, 32'hAABBCCDD);
    $display("flush in drain instr=%h", instr);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
